// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter.
//   state_e   : arbiter FSM states (IDLE, BUSY_IF, BUSY_LS, RESP)
//   MEM_BASE  : base address of the memory region served by the port
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2,
    RESP    = 2'd3
  } state_e;

  localparam logic [31:0] MEM_BASE = 32'h8000_0000;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single memory port.
//   clk, rst (sync, active-high)
//   if_*  : fetch read channel  (if_req/if_addr in, if_ready/if_rdata out)
//   ls_*  : LSU read/write channel (ls_req/ls_wen/ls_addr/ls_wdata/ls_wmask in,
//           ls_ready/ls_rdata out)
//   mem_* : memory port (mem_req + latched fields out, mem_rdata/mem_valid in)
//   err   : pulses with ready when the transaction timed out
// LSU has priority unless it has starved a pending fetch STARVE_MAX times in a
// row. A transaction with no mem_valid within TIMEOUT busy cycles completes
// with zero data and err.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [63:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_wen,
  input  logic [31:0] ls_addr,
  input  logic [63:0] ls_wdata,
  input  logic [7:0]  ls_wmask,
  output logic        ls_ready,
  output logic [63:0] ls_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [63:0] mem_rdata,
  input  logic        mem_valid,
  output logic        err
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          mem_req_q, mem_req_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic          mem_wen_q, mem_wen_d;
  logic [63:0]   mem_wdata_q, mem_wdata_d;
  logic [7:0]    mem_wmask_q, mem_wmask_d;
  logic          if_ready_q, if_ready_d;
  logic [63:0]   if_rdata_q, if_rdata_d;
  logic          ls_ready_q, ls_ready_d;
  logic [63:0]   ls_rdata_q, ls_rdata_d;
  logic          err_q, err_d;
  logic          ls_wins;

  // LSU loses a simultaneous request only once the fetch has been starved
  // STARVE_MAX consecutive times.
  assign ls_wins = ls_req && !(if_req && (starve_q == STARVE_SAT));

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wen_d   = mem_wen_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    if_ready_d  = 1'b0;
    ls_ready_d  = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (ls_wins) begin
          state_d     = BUSY_LS;
          mem_req_d   = 1'b1;
          mem_addr_d  = ls_addr;
          mem_wen_d   = ls_wen;
          mem_wdata_d = ls_wdata;
          mem_wmask_d = ls_wmask;
          tmo_d       = '0;
          // ls_wins with if_req pending implies starve_q < STARVE_SAT,
          // so this increment cannot overflow the saturation point.
          if (if_req) starve_d = starve_q + SW'(1);
        end else if (if_req) begin
          state_d     = BUSY_IF;
          mem_req_d   = 1'b1;
          mem_addr_d  = if_addr;
          mem_wen_d   = 1'b0;
          mem_wdata_d = '0;
          mem_wmask_d = '0;
          tmo_d       = '0;
          starve_d    = '0;
        end
      end
      BUSY_IF, BUSY_LS: begin
        // tmo_q counts completed busy cycles; TMO_LAST marks the final one.
        if (mem_valid || (tmo_q == TMO_LAST)) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          tmo_d     = '0;
          err_d     = !mem_valid;
          if (state_q == BUSY_IF) begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_valid ? mem_rdata : '0;
          end else begin
            ls_ready_d = 1'b1;
            ls_rdata_d = mem_valid ? mem_rdata : '0;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RESP: begin
        state_d    = IDLE;
        if_rdata_d = '0;
        ls_rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      if_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      ls_ready_q  <= 1'b0;
      ls_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wen_q   <= mem_wen_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      if_ready_q  <= if_ready_d;
      if_rdata_q  <= if_rdata_d;
      ls_ready_q  <= ls_ready_d;
      ls_rdata_q  <= ls_rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wen   = mem_wen_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign if_ready  = if_ready_q;
  assign if_rdata  = if_rdata_q;
  assign ls_ready  = ls_ready_q;
  assign ls_rdata  = ls_rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-by-cycle vector table for the
// single-fetch, contention and spurious-valid cases, then hand sequences for
// starvation, timeout and reset in the middle of a transaction.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [63:0] if_rdata;
  logic        ls_req;
  logic        ls_wen;
  logic [31:0] ls_addr;
  logic [63:0] ls_wdata;
  logic [7:0]  ls_wmask;
  logic        ls_ready;
  logic [63:0] ls_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic [63:0] mem_rdata;
  logic        mem_valid;
  logic        err;

  mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_wen(ls_wen), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wmask(ls_wmask), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid), .err(err)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] IF1 = MEM_BASE + 32'h10;
  localparam logic [31:0] IF2 = MEM_BASE + 32'h20;
  localparam logic [31:0] LS1 = MEM_BASE + 32'h100;
  localparam logic [31:0] LS2 = MEM_BASE + 32'h200;
  localparam logic [63:0] WD  = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] D1  = 64'h1122_3344_5566_7788;
  localparam logic [63:0] D2  = 64'hAAAA_5555_AAAA_5555;
  localparam logic [63:0] D3  = 64'h0102_0304_0506_0708;
  localparam logic [63:0] D4  = 64'h8899_AABB_CCDD_EEFF;
  localparam logic [63:0] DX  = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_wen;
    logic [31:0] ls_addr;
    logic [63:0] ls_wdata;
    logic [7:0]  ls_wmask;
    logic        mem_valid;
    logic [63:0] mem_rdata;
    logic        e_mem_req;
    logic [31:0] e_mem_addr;
    logic        e_mem_wen;
    logic [63:0] e_mem_wdata;
    logic [7:0]  e_mem_wmask;
    logic        e_if_ready;
    logic [63:0] e_if_rdata;
    logic        e_ls_ready;
    logic [63:0] e_ls_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req    = 1'b0;
    if_addr   = '0;
    ls_req    = 1'b0;
    ls_wen    = 1'b0;
    ls_addr   = '0;
    ls_wdata  = '0;
    ls_wmask  = '0;
    mem_valid = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_if_ready"}, 64'(if_ready), 64'd0);
    check({tag, "_ls_ready"}, 64'(ls_ready), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    //            rst if  ifaddr ls  wen lsaddr lswd lsm    mv  mrd  | mreq maddr wen wdata wmask  ifr ifrd lsr lsrd err
    vecs.push_back('{1, 0, 0,   0, 0, 0,   0,  8'h00, 0, 0,   0, 0,   0, 0,  8'h00, 0, 0,  0, 0,  0});
    // single fetch, mem_valid three cycles after mem_req
    vecs.push_back('{0, 1, IF1, 0, 0, 0,   0,  8'h00, 0, 0,   1, IF1, 0, 0,  8'h00, 0, 0,  0, 0,  0});
    vecs.push_back('{0, 1, IF1, 0, 0, 0,   0,  8'h00, 0, 0,   1, IF1, 0, 0,  8'h00, 0, 0,  0, 0,  0});
    vecs.push_back('{0, 1, IF1, 0, 0, 0,   0,  8'h00, 0, 0,   1, IF1, 0, 0,  8'h00, 0, 0,  0, 0,  0});
    vecs.push_back('{0, 1, IF1, 0, 0, 0,   0,  8'h00, 0, 0,   1, IF1, 0, 0,  8'h00, 0, 0,  0, 0,  0});
    vecs.push_back('{0, 1, IF1, 0, 0, 0,   0,  8'h00, 1, D1,  0, IF1, 0, 0,  8'h00, 1, D1, 0, 0,  0});
    vecs.push_back('{0, 0, 0,   0, 0, 0,   0,  8'h00, 0, 0,   0, IF1, 0, 0,  8'h00, 0, 0,  0, 0,  0});
    // contention: LSU write wins, IF follows after ls_ready
    vecs.push_back('{0, 1, IF2, 1, 1, LS1, WD, 8'h0F, 0, 0,   1, LS1, 1, WD, 8'h0F, 0, 0,  0, 0,  0});
    vecs.push_back('{0, 1, IF2, 1, 1, LS1, WD, 8'h0F, 1, D2,  0, LS1, 1, WD, 8'h0F, 0, 0,  1, D2, 0});
    vecs.push_back('{0, 1, IF2, 0, 0, 0,   0,  8'h00, 0, 0,   0, LS1, 1, WD, 8'h0F, 0, 0,  0, 0,  0});
    vecs.push_back('{0, 1, IF2, 0, 0, 0,   0,  8'h00, 0, 0,   1, IF2, 0, 0,  8'h00, 0, 0,  0, 0,  0});
    vecs.push_back('{0, 1, IF2, 0, 0, 0,   0,  8'h00, 1, D3,  0, IF2, 0, 0,  8'h00, 1, D3, 0, 0,  0});
    vecs.push_back('{0, 0, 0,   0, 0, 0,   0,  8'h00, 0, 0,   0, IF2, 0, 0,  8'h00, 0, 0,  0, 0,  0});
    // spurious mem_valid in IDLE, then a normal LSU read proves FSM stayed IDLE
    vecs.push_back('{0, 0, 0,   0, 0, 0,   0,  8'h00, 1, DX,  0, IF2, 0, 0,  8'h00, 0, 0,  0, 0,  0});
    vecs.push_back('{0, 0, 0,   1, 0, LS2, 0,  8'h00, 0, 0,   1, LS2, 0, 0,  8'h00, 0, 0,  0, 0,  0});
    vecs.push_back('{0, 0, 0,   1, 0, LS2, 0,  8'h00, 1, D4,  0, LS2, 0, 0,  8'h00, 0, 0,  1, D4, 0});
    vecs.push_back('{0, 0, 0,   0, 0, 0,   0,  8'h00, 0, 0,   0, LS2, 0, 0,  8'h00, 0, 0,  0, 0,  0});

    foreach (vecs[i]) begin
      rst       = vecs[i].rst;
      if_req    = vecs[i].if_req;
      if_addr   = vecs[i].if_addr;
      ls_req    = vecs[i].ls_req;
      ls_wen    = vecs[i].ls_wen;
      ls_addr   = vecs[i].ls_addr;
      ls_wdata  = vecs[i].ls_wdata;
      ls_wmask  = vecs[i].ls_wmask;
      mem_valid = vecs[i].mem_valid;
      mem_rdata = vecs[i].mem_rdata;
      step();
      check($sformatf("v%0d_mem_req", i),   64'(mem_req),   64'(vecs[i].e_mem_req));
      check($sformatf("v%0d_mem_addr", i),  64'(mem_addr),  64'(vecs[i].e_mem_addr));
      check($sformatf("v%0d_mem_wen", i),   64'(mem_wen),   64'(vecs[i].e_mem_wen));
      check($sformatf("v%0d_mem_wdata", i), mem_wdata,      vecs[i].e_mem_wdata);
      check($sformatf("v%0d_mem_wmask", i), 64'(mem_wmask), 64'(vecs[i].e_mem_wmask));
      check($sformatf("v%0d_if_ready", i),  64'(if_ready),  64'(vecs[i].e_if_ready));
      check($sformatf("v%0d_if_rdata", i),  if_rdata,       vecs[i].e_if_rdata);
      check($sformatf("v%0d_ls_ready", i),  64'(ls_ready),  64'(vecs[i].e_ls_ready));
      check($sformatf("v%0d_ls_rdata", i),  ls_rdata,       vecs[i].e_ls_rdata);
      check($sformatf("v%0d_err", i),       64'(err),       64'(vecs[i].e_err));
    end
    rst = 1'b0;

    // Starvation: LSU re-requests back to back while IF waits.
    begin
      logic grant_is_ls[5];
      int   ngr = 0;
      logic prev_req = 1'b0;
      do_reset();
      if_req   = 1'b1;
      if_addr  = IF1;
      ls_req   = 1'b1;
      ls_wen   = 1'b1;
      ls_addr  = LS1;
      ls_wdata = WD;
      ls_wmask = 8'hFF;
      for (int cyc = 0; cyc < 300 && ngr < 5; cyc++) begin
        step();
        if (mem_req && !prev_req) begin
          grant_is_ls[ngr] = (mem_addr == LS1) && mem_wen;
          ngr++;
        end
        if (if_ready) if_req = 1'b0;
        prev_req  = mem_req;
        mem_valid = mem_req;
        mem_rdata = D1;
      end
      check("starve_grant_count", 64'(ngr), 64'd5);
      for (int i = 0; i < 4; i++)
        check($sformatf("starve_ls_grant%0d", i), 64'(grant_is_ls[i]), 64'd1);
      check("starve_if_grant", 64'(grant_is_ls[4]), 64'd0);
      check("starve_if_addr", 64'(mem_addr), 64'(IF1));
    end

    // Timeout: LSU read with mem_valid withheld.
    begin
      int busy = 0;
      do_reset();
      ls_req  = 1'b1;
      ls_addr = LS2;
      step();
      check("tmo_granted", 64'(mem_req), 64'd1);
      if (mem_req) busy = 1;
      for (int cyc = 0; cyc < 400 && !ls_ready; cyc++) begin
        step();
        if (!ls_ready && mem_req) busy++;
      end
      check("tmo_busy_cycles", 64'(busy), 64'd255);
      check("tmo_ls_ready", 64'(ls_ready), 64'd1);
      check("tmo_err", 64'(err), 64'd1);
      check("tmo_ls_rdata", ls_rdata, 64'd0);
      check("tmo_mem_req", 64'(mem_req), 64'd0);
      check("tmo_if_ready", 64'(if_ready), 64'd0);
      ls_req = 1'b0;
      step();
      check("tmo_err_pulse", 64'(err), 64'd0);
      check("tmo_ready_pulse", 64'(ls_ready), 64'd0);
    end

    // Reset while BUSY: transaction abandoned, late mem_valid ignored.
    begin
      int readies = 0;
      do_reset();
      ls_req  = 1'b1;
      ls_addr = LS1;
      step();
      step();
      check("rstbusy_mem_req_before", 64'(mem_req), 64'd1);
      rst    = 1'b1;
      ls_req = 1'b0;
      step();
      rst = 1'b0;
      check_all_zero("rstbusy");
      mem_valid = 1'b1;
      mem_rdata = D2;
      step();
      mem_valid = 1'b0;
      if (ls_ready || if_ready) readies++;
      step();
      if (ls_ready || if_ready) readies++;
      check("rstbusy_no_ready", 64'(readies), 64'd0);
      check("rstbusy_ls_rdata", ls_rdata, 64'd0);
      // A fresh fetch is granted immediately, so the FSM is back in IDLE.
      if_req  = 1'b1;
      if_addr = IF2;
      step();
      check("rstbusy_idle_grant", 64'(mem_req), 64'd1);
      check("rstbusy_idle_addr", 64'(mem_addr), 64'(IF2));
      if_req = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
